// File: rtl/rep4_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rep4_pkg
//  Description : Shared constants, counter widths and FSM state encoding for
//                the rep4_tx repetition-coded serial transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
package rep4_pkg;

   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int DATA_W     = 8;
   localparam int REP        = 4;
   localparam int FRAME_BITS = DATA_W + 1;
   localparam int COPY_W     = cnt_w(REP);
   localparam int BIT_W      = cnt_w(FRAME_BITS);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

endpackage
`default_nettype wire

// File: rtl/rep4_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : rep4_ctr
//  Description : Copy / frame-bit position counters. Cleared whenever adv is
//                low, so the first cycle after a transfer always reads 0/0.
//  Revision    : 1.0 - initial release
// ============================================================================
module rep4_ctr #(
   parameter int REP        = 4,
   parameter int FRAME_BITS = 9,
   parameter int COPY_W     = 2,
   parameter int BIT_W      = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              adv,
   output logic [COPY_W-1:0] next_copy,
   output logic              last_copy,
   output logic              last_bit
);

   logic [COPY_W-1:0] r_copy;
   logic [BIT_W-1:0]  r_bit;

   assign last_copy = (r_copy == COPY_W'(REP - 1));
   assign last_bit  = (r_bit == BIT_W'(FRAME_BITS - 1));
   assign next_copy = last_copy ? '0 : r_copy + COPY_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_copy <= '0;
         r_bit  <= '0;
      end else if (!adv) begin
         r_copy <= '0;
         r_bit  <= '0;
      end else begin
         r_copy <= next_copy;
         if (last_copy)
            r_bit <= last_bit ? '0 : r_bit + BIT_W'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/rep4_tx.sv
`default_nettype none
// ============================================================================
//  Module      : rep4_tx
//  Description : Serialises a payload plus odd parity, LSB first, sending each
//                bit REP times with optional single-copy error injection.
//  Revision    : 1.0 - initial release
// ============================================================================
module rep4_tx #(
   parameter int DATA_W = rep4_pkg::DATA_W,
   parameter int REP    = rep4_pkg::REP
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] din,
   input  logic              din_valid,
   output logic              din_ready,
   input  logic              inj_en,
   input  logic [1:0]        inj_copy,
   output logic              tx_bit,
   output logic              tx_frame,
   output logic              tx_bit_start
);
   import rep4_pkg::*;

   localparam int c_frame_bits = DATA_W + 1;
   localparam int c_copy_w     = cnt_w(REP);
   localparam int c_bit_w      = cnt_w(c_frame_bits);

   state_t                  r_state, w_state_nxt;
   logic [c_frame_bits-1:0] r_shift;
   logic                    r_inj_en;
   logic [1:0]              r_inj_copy;
   logic                    r_tx_bit, r_tx_frame, r_tx_bit_start;
   logic [c_copy_w-1:0]     w_next_copy;
   logic                    w_last_copy, w_last_bit;
   logic                    w_final, w_xfer, w_adv;
   logic                    w_bit_nxt, w_frame_nxt, w_start_nxt;

   rep4_ctr #(
      .REP        (REP),
      .FRAME_BITS (c_frame_bits),
      .COPY_W     (c_copy_w),
      .BIT_W      (c_bit_w)
   ) u_ctr (
      .clk       (clk),
      .rst_n     (rst_n),
      .adv       (w_adv),
      .next_copy (w_next_copy),
      .last_copy (w_last_copy),
      .last_bit  (w_last_bit)
   );

   assign w_final   = (r_state == SEND) && w_last_copy && w_last_bit;
   assign din_ready = (r_state == IDLE) || w_final;
   assign w_xfer    = din_valid && din_ready;
   assign w_adv     = (r_state == SEND) && !w_final;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // Outputs are computed one cycle ahead so the line is driven straight from flops.
   always_comb begin
      w_state_nxt = r_state;
      w_bit_nxt   = 1'b0;
      w_frame_nxt = 1'b0;
      w_start_nxt = 1'b0;
      if (w_xfer) begin
         w_state_nxt = SEND;
         w_bit_nxt   = din[0] ^ (inj_en && (inj_copy == 2'd0));
         w_frame_nxt = 1'b1;
         w_start_nxt = 1'b1;
      end else if (w_adv) begin
         w_bit_nxt   = (w_last_copy ? r_shift[1] : r_shift[0])
                       ^ (r_inj_en && (int'(w_next_copy) == int'(r_inj_copy)));
         w_frame_nxt = 1'b1;
         w_start_nxt = w_last_copy;
      end else begin
         w_state_nxt = IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shift        <= '0;
         r_inj_en       <= 1'b0;
         r_inj_copy     <= 2'd0;
         r_tx_bit       <= 1'b0;
         r_tx_frame     <= 1'b0;
         r_tx_bit_start <= 1'b0;
      end else begin
         r_tx_bit       <= w_bit_nxt;
         r_tx_frame     <= w_frame_nxt;
         r_tx_bit_start <= w_start_nxt;
         if (w_xfer) begin
            r_shift    <= {~^din, din};
            r_inj_en   <= inj_en;
            r_inj_copy <= inj_copy;
         end else if (w_adv) begin
            if (w_last_copy)
               r_shift <= r_shift >> 1;
         end else begin
            r_shift <= '0;
         end
      end
   end

   assign tx_bit       = r_tx_bit;
   assign tx_frame     = r_tx_frame;
   assign tx_bit_start = r_tx_bit_start;

endmodule
`default_nettype wire

// File: tb/tb_rep4_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_rep4_tx
//  Description : Scoreboard bench for rep4_tx with directed frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rep4_tx;
   localparam int DW = 8;
   localparam int RP = 4;
   localparam int NB = DW + 1;
   localparam int FL = NB * RP;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [DW-1:0] din = '0;
   logic          din_valid = 1'b0;
   logic          inj_en = 1'b0;
   logic [1:0]    inj_copy = 2'd0;
   logic          din_ready, tx_bit, tx_frame, tx_bit_start;

   always #5 clk = ~clk;

   rep4_tx #(.DATA_W(DW), .REP(RP)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .din          (din),
      .din_valid    (din_valid),
      .din_ready    (din_ready),
      .inj_en       (inj_en),
      .inj_copy     (inj_copy),
      .tx_bit       (tx_bit),
      .tx_frame     (tx_frame),
      .tx_bit_start (tx_bit_start)
   );

   typedef struct packed {
      logic          bit_v;
      logic          start;
      logic          last;
      logic [5:0]    pos;
      logic [NB-1:0] frame;
   } exp_t;

   exp_t          q[$];
   int            tests = 0;
   int            fails = 0;
   logic [FL-1:0] hist = '0;

   function automatic logic [NB-1:0] vote(input logic [FL-1:0] h);
      logic [NB-1:0] r;
      r = '0;
      for (int b = 0; b < NB; b++) begin
         int n = 0;
         for (int c = 0; c < RP; c++) n += int'(h[b*RP + c]);
         r[b] = (n >= 3);
      end
      return r;
   endfunction

   // Monitor: pops one expected sample per framed cycle, checks idle otherwise.
   always @(negedge clk) begin
      exp_t          e;
      logic [NB-1:0] dec;
      if (rst_n) begin
         if (tx_frame) begin
            tests++;
            if (q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_frame tx_frame=1 with nothing pending");
            end else begin
               e = q.pop_front();
               if ({tx_bit, tx_bit_start, din_ready} !== {e.bit_v, e.start, e.last}) begin
                  fails++;
                  $display("FAIL stream pos=%0d got bit/start/ready=%b%b%b want %b%b%b",
                           e.pos, tx_bit, tx_bit_start, din_ready, e.bit_v, e.start, e.last);
               end
               hist[e.pos] = tx_bit;
               if (e.last) begin
                  dec = vote(hist);
                  tests++;
                  if (dec !== e.frame) begin
                     fails++;
                     $display("FAIL vote got %h want %h", dec, e.frame);
                  end
               end
            end
         end else begin
            tests++;
            if (tx_bit !== 1'b0 || tx_bit_start !== 1'b0 || din_ready !== 1'b1 ||
                (q.size() > 0 && q[0].pos != 6'd0)) begin
               fails++;
               $display("FAIL idle bit=%b start=%b ready=%b pending=%0d want 0 0 1 no gap",
                        tx_bit, tx_bit_start, din_ready, q.size());
            end
         end
      end
   end

   task automatic issue(input logic [DW-1:0] d, input logic ie, input logic [1:0] ic,
                        input logic par, input bit no_wait);
      exp_t e;
      int   waited = 0;
      logic v;
      if (!no_wait) @(negedge clk);
      din = d; inj_en = ie; inj_copy = ic; din_valid = 1'b1;
      while (!din_ready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (!din_ready) begin
         tests++; fails++;
         $display("FAIL accept_timeout din_ready=%b want 1", din_ready);
         din_valid = 1'b0;
         return;
      end
      for (int b = 0; b < NB; b++) begin
         v = (b < DW) ? d[b] : par;
         for (int c = 0; c < RP; c++) begin
            e.bit_v = v ^ (ie && (c == int'(ic)));
            e.start = (c == 0);
            e.last  = (b == NB - 1) && (c == RP - 1);
            e.pos   = 6'(b * RP + c);
            e.frame = {par, d};
            q.push_back(e);
         end
      end
      @(posedge clk);
      #1;
      tests++;
      if (tx_frame !== 1'b1 || tx_bit_start !== 1'b1) begin
         fails++;
         $display("FAIL latency frame=%b start=%b want 1 1", tx_frame, tx_bit_start);
      end
   endtask

   task automatic drain();
      int n = 0;
      @(negedge clk);
      din_valid = 1'b0;
      while (q.size() > 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (q.size() > 0) begin
         tests++; fails++;
         $display("FAIL drain_timeout pending=%0d want 0", q.size());
         q.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   // Random input churn while the frame is in flight; never offer on the final cycle.
   task automatic churn();
      repeat (FL + 2) begin
         @(negedge clk);
         din      = DW'($urandom);
         inj_en   = 1'($urandom);
         inj_copy = 2'($urandom);
         din_valid = din_ready ? 1'b0 : 1'($urandom);
      end
      din_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #2;
      tests++;
      if (din_ready !== 1'b1 || tx_bit !== 1'b0 || tx_frame !== 1'b0 || tx_bit_start !== 1'b0) begin
         fails++;
         $display("FAIL reset_state ready=%b bit=%b frame=%b start=%b want 1 0 0 0",
                  din_ready, tx_bit, tx_frame, tx_bit_start);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      issue(8'h01, 1'b0, 2'd0, 1'b0, 1'b1);
      drain();

      issue(8'hA5, 1'b1, 2'd2, 1'b1, 1'b0);
      drain();

      issue(8'h00, 1'b0, 2'd0, 1'b1, 1'b0);
      issue(8'hFF, 1'b0, 2'd0, 1'b1, 1'b0);
      drain();

      issue(8'h5A, 1'b0, 2'd0, 1'b1, 1'b0);
      churn();
      drain();
      issue(8'h07, 1'b1, 2'd0, 1'b0, 1'b0);
      churn();
      drain();

      issue(8'h3C, 1'b0, 2'd0, 1'b1, 1'b0);
      din_valid = 1'b0;
      repeat (16) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if (tx_frame !== 1'b0 || tx_bit !== 1'b0 || tx_bit_start !== 1'b0 || din_ready !== 1'b1) begin
         fails++;
         $display("FAIL mid_reset frame=%b bit=%b start=%b ready=%b want 0 0 0 1",
                  tx_frame, tx_bit, tx_bit_start, din_ready);
      end
      q.delete();
      @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (10) @(negedge clk);

      issue(8'h80, 1'b1, 2'd3, 1'b0, 1'b0);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
